// File: rtl/wbuf_pkg.sv
// wbuf_pkg - shared widths, store-packet layout and sizing helper for the write buffer. Rev 1.0
`default_nettype none

package wbuf_pkg;

    localparam int WB_DATA_W = 71;
    localparam int WB_ADDR_W = 32;

    // Store packet layout: {size[2:0], data[31:0], wstrb[3:0], addr[31:0]}
    localparam int WB_ADDR_LSB  = 0;
    localparam int WB_WSTRB_LSB = 32;
    localparam int WB_WSTRB_W   = 4;
    localparam int WB_DATA_LSB  = 36;
    localparam int WB_WDATA_W   = 32;

    function automatic int wb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wbuf_match.sv
// wbuf_match - picks the youngest valid entry whose address matches, as a one-hot select. Rev 1.0
`default_nettype none

module wbuf_match #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] match,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic             hit,
    output logic [DEPTH-1:0] sel
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0] w_cand;
    logic [PTR_W-1:0] w_slot [DEPTH];

    assign w_cand = valid & match;

    // w_slot[k] is the physical index of the entry whose age is k
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_slot
            logic [PTR_W:0] w_sum;
            assign w_sum     = {1'b0, rd_ptr} + (PTR_W+1)'(k);
            assign w_slot[k] = (w_sum >= DEPTH_CNT) ? PTR_W'(w_sum - DEPTH_CNT)
                                                    : w_sum[PTR_W-1:0];
        end
    endgenerate

    // Scan oldest to youngest so the last candidate seen wins.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_cand[w_slot[k]]) begin
                sel            = '0;
                sel[w_slot[k]] = 1'b1;
                hit            = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wbuf_fifo.sv
// wbuf_fifo - store write-buffer queue with occupancy flags, flush and youngest-match address lookup. Rev 1.0
`default_nettype none

module wbuf_fifo
    import wbuf_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DATA_W    = WB_DATA_W,
    parameter int ADDR_W    = WB_ADDR_W,
    parameter int AFULL_LVL = 6,
    parameter int PTR_W     = wb_ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    input  logic              pop_ready,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data
);

    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   AFULL_CNT = (PTR_W+1)'(AFULL_LVL);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic              w_push_fire;
    logic              w_pop_fire;
    logic [DEPTH-1:0]  w_match;
    logic [DEPTH-1:0]  w_sel;

    assign count       = r_count;
    assign empty       = (r_count == '0);
    assign full        = (r_count == FULL_CNT);
    assign almost_full = (r_count >= AFULL_CNT);
    assign pop_valid   = ~empty;
    assign pop_data    = pop_valid ? r_mem[r_rd_ptr] : '0;

    // A full queue still accepts when the head leaves this same cycle.
    assign push_ready  = ~flush & (~full | pop_ready);
    assign w_push_fire = push_valid & push_ready;
    assign w_pop_fire  = pop_valid & pop_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push_fire) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_fire) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push_fire && !w_pop_fire) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_fire && w_pop_fire) begin
                r_count <= r_count - 1'b1;
            end
            // Set after clear: a full-queue push/pop on one index keeps it valid.
            if (w_pop_fire) begin
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (w_push_fire) begin
                r_valid[r_wr_ptr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_fire) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
            assign w_match[i] = (r_mem[i][WB_ADDR_LSB +: ADDR_W] == lookup_addr);
        end
    endgenerate

    wbuf_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .valid  (r_valid),
        .match  (w_match),
        .rd_ptr (r_rd_ptr),
        .hit    (lookup_hit),
        .sel    (w_sel)
    );

    always_comb begin
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) begin
                lookup_data = lookup_data | r_mem[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wbuf_fifo.sv
// tb_wbuf_fifo - directed self-checking bench for wbuf_fifo (DEPTH=8 and DEPTH=6 instances). Rev 1.0
`default_nettype none

module tb_wbuf_fifo;

    localparam int DW = 71;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          flush, push_valid, pop_ready;
    logic [DW-1:0] push_data;
    logic [31:0]   lookup_addr;
    logic          push_ready, pop_valid, empty, full, almost_full, lookup_hit;
    logic [DW-1:0] pop_data, lookup_data;
    logic [3:0]    count;

    logic          s_flush, s_push_valid, s_pop_ready;
    logic [DW-1:0] s_push_data;
    logic [31:0]   s_lookup_addr;
    logic          s_push_ready, s_pop_valid, s_empty, s_full, s_almost_full, s_lookup_hit;
    logic [DW-1:0] s_pop_data, s_lookup_data;
    logic [3:0]    s_count;

    int n_checks = 0;
    int n_pass   = 0;

    wbuf_fifo #(.DEPTH(8), .AFULL_LVL(6)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data)
    );

    wbuf_fifo #(.DEPTH(6), .AFULL_LVL(4)) dut6 (
        .clk(clk), .resetn(resetn), .flush(s_flush),
        .push_valid(s_push_valid), .push_data(s_push_data), .push_ready(s_push_ready),
        .pop_valid(s_pop_valid), .pop_data(s_pop_data), .pop_ready(s_pop_ready),
        .count(s_count), .empty(s_empty), .full(s_full), .almost_full(s_almost_full),
        .lookup_addr(s_lookup_addr), .lookup_hit(s_lookup_hit), .lookup_data(s_lookup_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            push_valid = 1'b1;
            push_data  = DW'(base + i);
            step();
        end
        push_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++; if (empty !== 1'b1) $display("FAIL %s empty: got %b want 1", tag, empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL %s full: got %b want 0", tag, full); else n_pass++;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL %s almost_full: got %b want 0", tag, almost_full); else n_pass++;
        n_checks++; if (pop_valid !== 1'b0) $display("FAIL %s pop_valid: got %b want 0", tag, pop_valid); else n_pass++;
        n_checks++; if (pop_data !== '0) $display("FAIL %s pop_data: got %h want 0", tag, pop_data); else n_pass++;
        n_checks++; if (lookup_hit !== 1'b0) $display("FAIL %s lookup_hit: got %b want 0", tag, lookup_hit); else n_pass++;
        n_checks++; if (lookup_data !== '0) $display("FAIL %s lookup_data: got %h want 0", tag, lookup_data); else n_pass++;
        n_checks++; if (push_ready !== 1'b1) $display("FAIL %s push_ready: got %b want 1", tag, push_ready); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL %s count: got %0d want 0", tag, count); else n_pass++;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        push_data = '0; lookup_addr = '0;
        s_flush = 1'b0; s_push_valid = 1'b0; s_pop_ready = 1'b0;
        s_push_data = '0; s_lookup_addr = '0;
        step(); step();
        resetn = 1'b1;
        #1;
        check_reset_outputs("reset");
        n_checks++; if (s_empty !== 1'b1) $display("FAIL reset s_empty: got %b want 1", s_empty); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            push_valid = 1'b1;
            push_data  = DW'(32'h11 + i);
            #1;
            n_checks++; if (push_ready !== 1'b1) $display("FAIL fill_ready[%0d]: got %b want 1", i, push_ready); else n_pass++;
            step();
            push_valid = 1'b0;
            #1;
            n_checks++; if (count !== 4'(i + 1)) $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); else n_pass++;
            n_checks++; if (almost_full !== (i >= 5)) $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, (i >= 5)); else n_pass++;
            n_checks++; if (full !== (i == 7)) $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 7)); else n_pass++;
        end
        push_valid = 1'b1;
        push_data  = DW'(32'h99);
        #1;
        n_checks++; if (push_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", push_ready); else n_pass++;
        step();
        push_valid = 1'b0;
        n_checks++; if (count !== 4'd8) $display("FAIL full_drop_count: got %0d want 8", count); else n_pass++;
    endtask

    task automatic test_drain();
        pop_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++; if (pop_valid !== 1'b1) $display("FAIL drain_valid[%0d]: got %b want 1", i, pop_valid); else n_pass++;
            n_checks++; if (pop_data !== DW'(32'h11 + i)) $display("FAIL drain_data[%0d]: got %h want %h", i, pop_data, 32'h11 + i); else n_pass++;
            step();
        end
        pop_ready = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (pop_data !== '0) $display("FAIL drain_pop_data: got %h want 0", pop_data); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL drain_count: got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_tail [8];
        exp_tail = '{8'h16, 8'h17, 8'h18, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        push_n(32'h11, 8);
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1;
            push_data  = DW'(32'h21 + i);
            pop_ready  = 1'b1;
            #1;
            n_checks++; if (push_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, push_ready); else n_pass++;
            n_checks++; if (pop_data !== DW'(32'h11 + i)) $display("FAIL b2b_head[%0d]: got %h want %h", i, pop_data, 32'h11 + i); else n_pass++;
            step();
            n_checks++; if (count !== 4'd8) $display("FAIL b2b_count[%0d]: got %0d want 8", i, count); else n_pass++;
        end
        push_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++; if (pop_data !== DW'(exp_tail[i])) $display("FAIL b2b_tail[%0d]: got %h want %h", i, pop_data, exp_tail[i]); else n_pass++;
            step();
        end
        pop_ready = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1) $display("FAIL b2b_empty: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_wrap_depth6();
        int n_push = 0;
        int n_pop  = 0;
        for (int i = 0; i < 3; i++) begin
            s_push_valid = 1'b1;
            s_push_data  = DW'(32'h40 + n_push);
            step();
            n_push++;
        end
        s_push_valid = 1'b0;
        // Pattern per 3 cycles: push only, push+pop, pop only; occupancy stays 3..4.
        for (int k = 0; k < 20; k++) begin
            s_push_valid = ((k % 3) != 2);
            s_pop_ready  = ((k % 3) != 0);
            s_push_data  = DW'(32'h40 + n_push);
            #1;
            if ((k % 3) != 0) begin
                n_checks++; if (s_pop_data !== DW'(32'h40 + n_pop)) $display("FAIL wrap_data[%0d]: got %h want %h", k, s_pop_data, 32'h40 + n_pop); else n_pass++;
            end
            step();
            if ((k % 3) != 2) n_push++;
            if ((k % 3) != 0) n_pop++;
            n_checks++; if (s_count !== 4'(n_push - n_pop)) $display("FAIL wrap_count[%0d]: got %0d want %0d", k, s_count, n_push - n_pop); else n_pass++;
        end
        s_push_valid = 1'b0;
        s_pop_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (s_pop_data !== DW'(32'h40 + n_pop)) $display("FAIL wrap_drain[%0d]: got %h want %h", i, s_pop_data, 32'h40 + n_pop); else n_pass++;
            step();
            n_pop++;
        end
        s_pop_ready = 1'b0;
        #1;
        n_checks++; if (s_empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", s_empty); else n_pass++;
    endtask

    task automatic test_lookup();
        logic [DW-1:0] pa, pb, pc;
        pa = {39'hA, 32'h100};
        pb = {39'hB, 32'h200};
        pc = {39'hC, 32'h100};
        push_valid = 1'b1;
        push_data = pa; step();
        push_data = pb; step();
        push_data = pc; step();
        push_valid = 1'b0;
        lookup_addr = 32'h100;
        #1;
        n_checks++; if (lookup_hit !== 1'b1) $display("FAIL lk_hit_100: got %b want 1", lookup_hit); else n_pass++;
        n_checks++; if (lookup_data !== pc) $display("FAIL lk_data_100: got %h want %h", lookup_data, pc); else n_pass++;
        lookup_addr = 32'h200;
        #1;
        n_checks++; if (lookup_data !== pb) $display("FAIL lk_data_200: got %h want %h", lookup_data, pb); else n_pass++;
        pop_ready = 1'b1;
        step(); step();
        pop_ready = 1'b0;
        lookup_addr = 32'h100;
        #1;
        n_checks++; if (lookup_hit !== 1'b1) $display("FAIL lk_post_hit_100: got %b want 1", lookup_hit); else n_pass++;
        n_checks++; if (lookup_data !== pc) $display("FAIL lk_post_data_100: got %h want %h", lookup_data, pc); else n_pass++;
        lookup_addr = 32'h200;
        #1;
        n_checks++; if (lookup_hit !== 1'b0) $display("FAIL lk_post_hit_200: got %b want 0", lookup_hit); else n_pass++;
        n_checks++; if (lookup_data !== '0) $display("FAIL lk_post_data_200: got %h want 0", lookup_data); else n_pass++;
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
    endtask

    task automatic test_flush();
        push_n(32'h31, 4);
        flush      = 1'b1;
        push_valid = 1'b1;
        push_data  = DW'(32'h99);
        pop_ready  = 1'b1;
        #1;
        n_checks++; if (push_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", push_ready); else n_pass++;
        step();
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        lookup_addr = 32'h31;
        #1;
        n_checks++; if (count !== 4'd0) $display("FAIL flush_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL flush_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (lookup_hit !== 1'b0) $display("FAIL flush_hit_31: got %b want 0", lookup_hit); else n_pass++;
        lookup_addr = 32'h99;
        #1;
        n_checks++; if (lookup_hit !== 1'b0) $display("FAIL flush_hit_99: got %b want 0", lookup_hit); else n_pass++;
        push_n(32'h55, 1);
        #1;
        n_checks++; if (pop_data !== DW'(32'h55)) $display("FAIL flush_next_data: got %h want 55", pop_data); else n_pass++;
        n_checks++; if (count !== 4'd1) $display("FAIL flush_next_count: got %0d want 1", count); else n_pass++;
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_n(32'h61, 3);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        lookup_addr = 32'h61;
        #1;
        check_reset_outputs("reset_mid");
        push_n(32'h77, 1);
        lookup_addr = 32'h77;
        #1;
        n_checks++; if (count !== 4'd1) $display("FAIL rmid_count: got %0d want 1", count); else n_pass++;
        n_checks++; if (pop_data !== DW'(32'h77)) $display("FAIL rmid_data: got %h want 77", pop_data); else n_pass++;
        n_checks++; if (lookup_hit !== 1'b1) $display("FAIL rmid_hit: got %b want 1", lookup_hit); else n_pass++;
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_wrap_depth6();
        test_lookup();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
